// File: rtl/test_monitor.sv
// test_monitor: end-of-test monitor for the CPU SoC.
//   Snoops the data-memory write port for the tohost mailbox and reports
//   pass / fail / timeout. It also emits heartbeat ticks while the test runs
//   and flags changes on the watched LED lines.
//
// Optional feature macro: TEST_MONITOR_LEDLOG_EN
//   defined   -> led_events_o counts led_change pulses (saturating at 16'hFFFF)
//   undefined -> led_events_o tied to 0; no counter is built
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   reset_i        synchronous, active-high reset
//   mem_write_i    data write strobe
//   mem_addr_i     write address            [ADDR_WIDTH]
//   mem_wdata_i    write data               [DATA_WIDTH]
//   leds_i         LED levels to watch      [NUM_LEDS]
//   done_o         sticky: test ended (pass | fail | timeout)
//   pass_o         sticky: tohost written with 0
//   fail_o         sticky: tohost written with nonzero
//   timeout_o      sticky: watchdog expired
//   fail_code_o    data of the failing tohost write [DATA_WIDTH]
//   cycle_count_o  cycles spent in RUN, saturating  [CNT_WIDTH]
//   heartbeat_o    1-cycle pulse every HEARTBEAT_CYCLES while in RUN
//   led_change_o   1-cycle pulse when leds differ from the previous sample
//   led_events_o   number of led_change pulses     [16]
//
// state   | meaning
// --------+--------------------------------------------------
// S_RUN   | test in progress, counters and watchdog active
// S_PASS  | tohost written with 0, terminal until reset
// S_FAIL  | tohost written with nonzero, terminal until reset
// S_TMO   | watchdog expired, terminal until reset

module test_monitor #(
  parameter int                    ADDR_WIDTH       = 32,
  parameter int                    DATA_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR      = 'h20004,
  parameter int                    NUM_LEDS         = 5,
  parameter int                    HEARTBEAT_CYCLES = 50000,
  parameter int                    TIMEOUT_CYCLES   = 300000,
  parameter int                    CNT_WIDTH        = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  mem_write_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic [NUM_LEDS-1:0]   leds_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] fail_code_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o,
  output logic                  heartbeat_o,
  output logic                  led_change_o,
  output logic [15:0]           led_events_o
);

  localparam int                   HB_W    = $clog2(HEARTBEAT_CYCLES);
  localparam logic [HB_W-1:0]      HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [HB_W-1:0]      HB_ONE  = HB_W'(1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TMO} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic [HB_W-1:0]       hb_cnt_q, hb_cnt_d;
  logic                  hb_wrap;
  logic                  tohost_wr;
  logic                  stay_run;

  logic                  done_q, pass_q, fail_q, timeout_q;
  logic [DATA_WIDTH-1:0] fail_code_q;
  logic                  heartbeat_q;
  logic [NUM_LEDS-1:0]   led_q;
  logic                  led_valid_q;
  logic                  led_change_q;

  always_comb begin
    tohost_wr     = mem_write_i && (mem_addr_i == TOHOST_ADDR);
    state_d       = state_q;
    cycle_count_d = cycle_count_q;
    hb_cnt_d      = hb_cnt_q;
    hb_wrap       = 1'b0;

    if (state_q == S_RUN) begin
      // A tohost write beats the watchdog in the same cycle.
      if (tohost_wr) begin
        state_d = (mem_wdata_i == '0) ? S_PASS : S_FAIL;
      end else if (cycle_count_q == TO_LAST) begin
        state_d = S_TMO;
      end
    end

    // Counters only advance on cycles that remain in RUN, so the count
    // freezes at the value it held in the last RUN cycle.
    stay_run = (state_d == S_RUN);

    if (stay_run) begin
      if (cycle_count_q != '1) begin
        cycle_count_d = cycle_count_q + CNT_ONE;
      end
      if (hb_cnt_q == HB_LAST) begin
        hb_cnt_d = '0;
        hb_wrap  = 1'b1;
      end else begin
        hb_cnt_d = hb_cnt_q + HB_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_RUN;
      cycle_count_q <= '0;
      hb_cnt_q      <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      heartbeat_q   <= 1'b0;
      led_q         <= '0;
      led_valid_q   <= 1'b0;
      led_change_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
      hb_cnt_q      <= hb_cnt_d;
      heartbeat_q   <= hb_wrap;
      done_q        <= (state_d != S_RUN);
      pass_q        <= (state_d == S_PASS);
      fail_q        <= (state_d == S_FAIL);
      timeout_q     <= (state_d == S_TMO);
      if ((state_q == S_RUN) && (state_d == S_FAIL)) begin
        fail_code_q <= mem_wdata_i;
      end
      // The first sample after reset only primes the comparison.
      led_q         <= leds_i;
      led_valid_q   <= 1'b1;
      led_change_q  <= led_valid_q && (leds_i != led_q);
    end
  end

`ifdef TEST_MONITOR_LEDLOG_EN
  logic [15:0] led_events_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      led_events_q <= '0;
    end else if (led_change_q && (led_events_q != 16'hFFFF)) begin
      led_events_q <= led_events_q + 16'd1;
    end
  end

  assign led_events_o = led_events_q;
`else
  assign led_events_o = '0;
`endif

  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign fail_o        = fail_q;
  assign timeout_o     = timeout_q;
  assign fail_code_o   = fail_code_q;
  assign cycle_count_o = cycle_count_q;
  assign heartbeat_o   = heartbeat_q;
  assign led_change_o  = led_change_q;

endmodule

// File: tb/tb_test_monitor.sv
// Self-checking bench for test_monitor (short heartbeat and watchdog periods).
module tb_test_monitor;

  localparam logic [31:0] TOHOST = 32'h20004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [4:0]  leds = '0;
  logic        done, pass, fail, tmo, heartbeat, led_change;
  logic [31:0] fail_code, cycle_count;
  logic [15:0] led_events;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [31:0] code;
    logic [31:0] cnt;
  } status_t;

  status_t     exp_q[$];
  logic        bit_q[$];
  logic [15:0] ev_q[$];

  always #5 clk = ~clk;

  test_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TOHOST_ADDR(32'h20004), .NUM_LEDS(5),
    .HEARTBEAT_CYCLES(10), .TIMEOUT_CYCLES(100), .CNT_WIDTH(32)
  ) dut (
    .clk_i(clk), .reset_i(reset), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .leds_i(leds), .done_o(done), .pass_o(pass),
    .fail_o(fail), .timeout_o(tmo), .fail_code_o(fail_code),
    .cycle_count_o(cycle_count), .heartbeat_o(heartbeat),
    .led_change_o(led_change), .led_events_o(led_events)
  );

  function automatic status_t mk(logic d, logic p, logic f, logic t,
                                 logic [31:0] code, logic [31:0] cnt);
    status_t s;
    s.done = d; s.pass = p; s.fail = f; s.tmo = t; s.code = code; s.cnt = cnt;
    return s;
  endfunction

  function automatic status_t observe();
    return mk(done, pass, fail, tmo, fail_code, cycle_count);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of RUN cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    mem_write = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_tohost(input logic [31:0] addr, input logic [31:0] data);
    mem_write = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    status_t e, o;
    reset = 1'b1;
    tick();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL reset_status: got %h expected %h", o, e);
    end
    ev_q.push_back(16'h0);
    tests_run++;
    if ({heartbeat, led_change, led_events} !== {2'b00, ev_q.pop_front()}) begin
      tests_failed++;
      $display("FAIL reset_pulses: got hb=%b lc=%b ev=%0d expected 0", heartbeat, led_change, led_events);
    end
    reset = 1'b0;
  endtask

  task automatic test_pass();
    status_t e, o;
    do_reset();
    repeat (10) tick();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 10));
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL pass_pre_write: got %h expected %h", o, e);
    end
    exp_q.push_back(mk(1, 1, 0, 0, 0, 10));
    write_tohost(TOHOST, 32'h0);
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL pass_at_11: got %h expected %h", o, e);
    end
  endtask

  task automatic test_fail_sticky();
    status_t e, o;
    do_reset();
    repeat (3) tick();
    exp_q.push_back(mk(1, 0, 1, 0, 32'h3, 3));
    write_tohost(TOHOST, 32'h3);
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL fail_code3: got %h expected %h", o, e);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(1, 0, 1, 0, 32'h3, 3));
      write_tohost(TOHOST, (i == 0) ? 32'h0 : 32'h7);
      e = exp_q.pop_front(); o = observe(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL fail_sticky_%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_timeout();
    status_t e, o;
    do_reset();
    repeat (99) tick();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 99));
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL timeout_cycle99: got %h expected %h", o, e);
    end
    tick();
    exp_q.push_back(mk(1, 0, 0, 1, 0, 99));
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL timeout_cycle100: got %h expected %h", o, e);
    end
    repeat (5) tick();
    exp_q.push_back(mk(1, 0, 0, 1, 0, 99));
    write_tohost(TOHOST, 32'h9);
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL timeout_frozen: got %h expected %h", o, e);
    end
  endtask

  task automatic test_timeout_priority();
    status_t e, o;
    do_reset();
    repeat (99) tick();
    exp_q.push_back(mk(1, 1, 0, 0, 0, 99));
    write_tohost(TOHOST, 32'h0);
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL tohost_beats_watchdog: got %h expected %h", o, e);
    end
    repeat (4) tick();
    exp_q.push_back(mk(1, 1, 0, 0, 0, 99));
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL pass_holds_after_wd: got %h expected %h", o, e);
    end
  endtask

  task automatic test_heartbeat();
    logic e;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      bit_q.push_back((c != 0) && (c % 10 == 0));
      e = bit_q.pop_front(); tests_run++;
      if (heartbeat !== e) begin
        tests_failed++;
        $display("FAIL heartbeat_c%0d: got %b expected %b", c, heartbeat, e);
      end
      if (c < 35) tick();
    end
    write_tohost(TOHOST, 32'h0);
    for (int c = 36; c < 61; c++) begin
      bit_q.push_back(1'b0);
      e = bit_q.pop_front(); tests_run++;
      if (heartbeat !== e) begin
        tests_failed++;
        $display("FAIL heartbeat_after_pass_c%0d: got %b expected %b", c, heartbeat, e);
      end
      tick();
    end
  endtask

  task automatic test_leds();
    logic        e;
    logic [4:0]  pat;
    logic [15:0] ev;
    leds = 5'b11010;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      bit_q.push_back((c == 2) || (c == 4));
      e = bit_q.pop_front(); tests_run++;
      if (led_change !== e) begin
        tests_failed++;
        $display("FAIL led_change_c%0d: got %b expected %b", c, led_change, e);
      end
      pat = (c == 0) ? 5'b00000 : (c < 3) ? 5'b00101 : 5'b11111;
      leds = pat;
      tick();
    end
`ifdef TEST_MONITOR_LEDLOG_EN
    ev_q.push_back(16'd2);
`else
    ev_q.push_back(16'd0);
`endif
    ev = ev_q.pop_front(); tests_run++;
    if (led_events !== ev) begin
      tests_failed++;
      $display("FAIL led_events: got %0d expected %0d", led_events, ev);
    end
  endtask

  task automatic test_mid_reset();
    status_t e, o;
    do_reset();
    repeat (5) tick();
    write_tohost(32'h20000, 32'h5);
    repeat (44) tick();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 50));
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL other_addr_ignored: got %h expected %h", o, e);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL mid_run_reset: got %h expected %h", o, e);
    end
    tick();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL count_restart: got %h expected %h", o, e);
    end
  endtask

  task automatic test_terminal_reset();
    status_t e, o;
    do_reset();
    exp_q.push_back(mk(1, 0, 1, 0, 32'h5, 0));
    write_tohost(TOHOST, 32'h5);
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL fail_at_cycle0: got %h expected %h", o, e);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); o = observe(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL terminal_reset: got %h expected %h", o, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_pass();
    test_fail_sticky();
    test_timeout();
    test_timeout_priority();
    test_heartbeat();
    test_leds();
    test_mid_reset();
    test_terminal_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
